// File: rtl/core_pkg.sv
// core_pkg: shared result-select encodings, NOP constant and IR field positions
package core_pkg;
  typedef enum logic [1:0] {
    RESSRC_ALURESULT = 2'b00,
    RESSRC_MEM       = 2'b01,
    RESSRC_ALUOUT    = 2'b10,
    RESSRC_ZERO      = 2'b11
  } ressrc_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7B5_BIT = 30;
endpackage

// File: rtl/en_reg.sv
// en_reg: width-parameterised register with async active-high reset and load enable
module en_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  // hold unless loading
  always_comb q_d = en ? d : q_q;
  // state with immediate reset
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= RST;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/datapath_regs.sv
// datapath_regs: multicycle RV32 state registers, result mux and instruction decode
module datapath_regs
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcwrite,
  input  logic            irwrite,
  input  logic            adrsource,
  input  logic [1:0]      resultsource,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            func7_bit5,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] a_reg,
  output logic [XLEN-1:0] b_reg,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] mdr,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            pc_misaligned,
  output logic [31:0]     instr_count
);
  logic [XLEN-1:0] pc_next;
  logic [31:0] cnt_next;
  logic mis_set;
  // result bus selects one of the holding registers or the live ALU output
  always_comb result = resultsource == RESSRC_ALURESULT ? alu_result :
                       resultsource == RESSRC_MEM       ? mdr :
                       resultsource == RESSRC_ALUOUT    ? alu_out : '0;
  // PC is always stored word-aligned; a dropped low bit is remembered as misalignment
  always_comb begin
    pc_next = {result[XLEN-1:2], 2'b00};
    mis_set = pcwrite & (|result[1:0]);
    cnt_next = instr_count + 32'd1;
  end
  assign mem_addr  = adrsource ? result : pc;
  assign mem_wdata = b_reg;
  assign opcode     = instr[OPC_MSB:OPC_LSB];
  assign rd         = instr[RD_MSB:RD_LSB];
  assign funct3     = instr[F3_MSB:F3_LSB];
  assign rs1        = instr[RS1_MSB:RS1_LSB];
  assign rs2        = instr[RS2_MSB:RS2_LSB];
  assign func7_bit5 = instr[F7B5_BIT];
  en_reg #(.W(XLEN), .RST(RESET_PC)) u_pc     (.clk, .reset, .en(pcwrite), .d(pc_next),    .q(pc));
  en_reg #(.W(XLEN), .RST(RESET_PC)) u_old_pc (.clk, .reset, .en(irwrite), .d(pc),         .q(old_pc));
  en_reg #(.W(32),   .RST(NOP_INSTR)) u_ir    (.clk, .reset, .en(irwrite), .d(mem_rdata),  .q(instr));
  en_reg #(.W(32))                   u_cnt    (.clk, .reset, .en(irwrite), .d(cnt_next),   .q(instr_count));
  en_reg #(.W(1))                    u_mis    (.clk, .reset, .en(mis_set), .d(1'b1),       .q(pc_misaligned));
  en_reg #(.W(XLEN))                 u_a      (.clk, .reset, .en(1'b1),    .d(rd1),        .q(a_reg));
  en_reg #(.W(XLEN))                 u_b      (.clk, .reset, .en(1'b1),    .d(rd2),        .q(b_reg));
  en_reg #(.W(XLEN))                 u_aluout (.clk, .reset, .en(1'b1),    .d(alu_result), .q(alu_out));
  en_reg #(.W(XLEN))                 u_mdr    (.clk, .reset, .en(1'b1),    .d(mem_rdata),  .q(mdr));
endmodule

// File: tb/tb_datapath_regs.sv
// tb_datapath_regs: directed stimulus with a behavioural model checked every cycle
module tb_datapath_regs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pcwrite = 1'b0, irwrite = 1'b0, adrsource = 1'b0;
  logic [1:0] resultsource = 2'b00;
  logic [31:0] alu_result = '0, mem_rdata = '0, rd1 = '0, rd2 = '0;
  logic [31:0] pc, old_pc, instr, a_reg, b_reg, alu_out, mdr, result, mem_addr, mem_wdata, instr_count;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic func7_bit5, pc_misaligned;
  logic [4:0] rs1, rs2, rd;
  int n_tests = 0;
  int n_fail = 0;

  datapath_regs #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .irwrite(irwrite), .adrsource(adrsource),
    .resultsource(resultsource), .alu_result(alu_result), .mem_rdata(mem_rdata), .rd1(rd1), .rd2(rd2),
    .pc(pc), .old_pc(old_pc), .instr(instr), .opcode(opcode), .funct3(funct3), .func7_bit5(func7_bit5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .a_reg(a_reg), .b_reg(b_reg), .alu_out(alu_out), .mdr(mdr),
    .result(result), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_misaligned(pc_misaligned),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc, m_old, m_ir, m_a, m_b, m_ao, m_mdr, m_cnt;
  logic m_mis;
  logic [31:0] cnt_bias = '0;

  function automatic logic [31:0] m_result(input logic [1:0] s, input logic [31:0] alu);
    case (s)
      2'd0: return alu;
      2'd1: return m_mdr;
      2'd2: return m_ao;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_pc <= 32'h100; m_old <= 32'h100; m_ir <= 32'h13;
      m_a <= 0; m_b <= 0; m_ao <= 0; m_mdr <= 0; m_cnt <= 0; m_mis <= 0;
    end else begin
      m_a <= rd1; m_b <= rd2; m_ao <= alu_result; m_mdr <= mem_rdata;
      if (irwrite) begin
        m_ir <= mem_rdata; m_old <= m_pc; m_cnt <= m_cnt + 1;
      end
      if (pcwrite) begin
        m_pc <= m_result(resultsource, alu_result) & ~32'd3;
        if (m_result(resultsource, alu_result) % 4 != 0) m_mis <= 1'b1;
      end
    end

  always @(negedge clk)
    if (!reset) begin
      chk("pc", pc, m_pc);
      chk("old_pc", old_pc, m_old);
      chk("instr", instr, m_ir);
      chk("opcode", {25'd0, opcode}, m_ir % 128);
      chk("rd", {27'd0, rd}, (m_ir >> 7) % 32);
      chk("funct3", {29'd0, funct3}, (m_ir >> 12) % 8);
      chk("rs1", {27'd0, rs1}, (m_ir >> 15) % 32);
      chk("rs2", {27'd0, rs2}, (m_ir >> 20) % 32);
      chk("func7_bit5", {31'd0, func7_bit5}, (m_ir >> 30) % 2);
      chk("a_reg", a_reg, m_a);
      chk("b_reg", b_reg, m_b);
      chk("mem_wdata", mem_wdata, m_b);
      chk("alu_out", alu_out, m_ao);
      chk("mdr", mdr, m_mdr);
      chk("result", result, m_result(resultsource, alu_result));
      chk("mem_addr", mem_addr, adrsource ? m_result(resultsource, alu_result) : m_pc);
      chk("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, m_mis});
      chk("instr_count", instr_count, m_cnt + cnt_bias);
    end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_old_pc", old_pc, 32'h100);
    chk("rst_instr", instr, 32'h13);
    chk("rst_opcode", {25'd0, opcode}, 32'h13);
    chk("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    mem_rdata = 32'h0051_8233; irwrite = 1'b1;
    tick;
    irwrite = 1'b0;
    chk("add_opcode", {25'd0, opcode}, 32'h33);
    chk("add_rd", {27'd0, rd}, 32'd4);
    chk("add_rs1", {27'd0, rs1}, 32'd3);
    chk("add_rs2", {27'd0, rs2}, 32'd5);
    chk("add_funct3", {29'd0, funct3}, 32'd0);
    chk("add_f7b5", {31'd0, func7_bit5}, 32'd0);
    chk("add_old_pc", old_pc, 32'h100);
    chk("add_count", instr_count, 32'd1);
    resultsource = 2'b00; alu_result = 32'h104; pcwrite = 1'b1;
    tick;
    chk("pc_104", pc, 32'h104);
    chk("mis_clear", {31'd0, pc_misaligned}, 32'd0);
    alu_result = 32'h10A;
    tick;
    chk("pc_108", pc, 32'h108);
    chk("mis_set", {31'd0, pc_misaligned}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      alu_result = 32'h10C + 32'(4 * i);
      tick;
    end
    chk("pc_11c", pc, 32'h11C);
    chk("mis_sticky", {31'd0, pc_misaligned}, 32'd1);
    alu_result = 32'h200;
    tick;
    alu_result = 32'h204; irwrite = 1'b1; mem_rdata = 32'h4000_0033;
    tick;
    pcwrite = 1'b0; irwrite = 1'b0;
    chk("both_old_pc", old_pc, 32'h200);
    chk("both_pc", pc, 32'h204);
    chk("both_count", instr_count, 32'd2);
    chk("sub_f7b5", {31'd0, func7_bit5}, 32'd1);
    mem_rdata = 32'h1111_0001; alu_result = 32'h2222_0002;
    tick;
    alu_result = 32'h3333_0003; rd2 = 32'hDEAD_BEEF;
    resultsource = 2'b00; #1 chk("mux_00", result, 32'h3333_0003);
    resultsource = 2'b01; #1 chk("mux_01", result, 32'h1111_0001);
    resultsource = 2'b10; #1 chk("mux_10", result, 32'h2222_0002);
    resultsource = 2'b11; #1 chk("mux_11", result, 32'd0);
    resultsource = 2'b00; adrsource = 1'b1;
    #1 chk("addr_result", mem_addr, 32'h3333_0003);
    adrsource = 1'b0;
    #1 chk("addr_pc", mem_addr, 32'h204);
    tick;
    chk("wdata", mem_wdata, 32'hDEAD_BEEF);
    #1 reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_old_pc", old_pc, 32'h100);
    chk("arst_instr", instr, 32'h13);
    chk("arst_count", instr_count, 32'd0);
    chk("arst_mis", {31'd0, pc_misaligned}, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    chk("post_rst_addr", mem_addr, 32'h100);
    cnt_bias = 32'hFFFF_FFFF - m_cnt;
    force dut.u_cnt.q_q = 32'hFFFF_FFFF;
    #1 release dut.u_cnt.q_q;
    chk("cnt_preload", instr_count, 32'hFFFF_FFFF);
    irwrite = 1'b1;
    tick;
    irwrite = 1'b0;
    chk("cnt_wrap", instr_count, 32'd0);
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_regs.md
# datapath_regs

Architectural and non-architectural state registers of the multicycle RV32 core, sitting directly downstream of the control unit. The block consumes `pcwrite`, `irwrite`, `adrsource` and `resultsource`, and holds PC, OldPC, IR, MDR, A, B and ALUOut. It drives the result bus, the memory address and the decoded instruction fields (`opcode`, `funct3`, `func7_bit5`) back to the control unit. It also keeps a sticky misaligned-PC flag and a retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width (only 32 supported)
- `RESET_PC`, 32'h0000_0000, PC and OldPC value after reset
- `clk` input 1 — single clock, rising edge
- `reset` input 1 — asynchronous, active-high
- `pcwrite` input 1 — load PC from `result`
- `irwrite` input 1 — load IR from `mem_rdata`, OldPC from PC
- `adrsource` input 1 — 0: `mem_addr`=PC, 1: `mem_addr`=`result`
- `resultsource` input 2 — 00 `alu_result`, 01 MDR, 10 ALUOut, 11 constant 0
- `alu_result` input XLEN — combinational ALU output
- `mem_rdata` input XLEN — memory read data
- `rd1`, `rd2` input XLEN — register-file read data
- `pc`, `old_pc` output XLEN — current and instruction-owning PC
- `instr` output 32 — IR contents
- `opcode` output 7, `funct3` output 3, `func7_bit5` output 1, `rs1`/`rs2`/`rd` output 5 — IR fields
- `a_reg`, `b_reg`, `alu_out`, `mdr` output XLEN — holding registers
- `result` output XLEN — result mux
- `mem_addr` output XLEN, `mem_wdata` output XLEN (= `b_reg`)
- `pc_misaligned` output 1 — sticky
- `instr_count` output 32 — count of IR loads

## Operation
- Reset (async, immediate): `pc`=`old_pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP; `opcode`=0010011, other fields 0), `a_reg`/`b_reg`/`alu_out`/`mdr`=0, `pc_misaligned`=0, `instr_count`=0.
- Every cycle, unconditionally: `a_reg`←`rd1`, `b_reg`←`rd2`, `alu_out`←`alu_result`, `mdr`←`mem_rdata`.
- `irwrite`=1: `instr`←`mem_rdata`, `old_pc`←pre-edge `pc`, `instr_count`←`instr_count`+1, wrapping 32'hFFFF_FFFF→0.
- `pcwrite`=1: `pc`←{`result`[31:2], 2'b00}. If `result`[1:0]≠0, set `pc_misaligned`; it is cleared only by reset.
- `irwrite` and `pcwrite` in the same cycle: both act. `old_pc` takes the pre-edge PC and `pc` takes the new value.
- `result` is combinational from the selected source. Select 11 drives 0.
- `mem_addr` is combinational: `pc` when `adrsource`=0, `result` when 1. No alignment masking.
- Decode fields are slices of `instr`: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], func7_bit5=instr[30].
- Reset asserted mid-instruction abandons all state. The first fetch after release is from `RESET_PC`.

## Timing
- All state updates occur on the rising `clk` edge after enables are sampled. Enables have no effect while `reset`=1.
- `result` and `mem_addr` follow their inputs combinationally, in zero cycles. All other outputs are registered with 1-cycle latency.
- `mdr` reflects memory data one cycle after address presentation. This matches the control unit's WRITEBACK step, which selects `resultsource`=01.
- IR fields are valid from the cycle after `irwrite` and remain stable until the next `irwrite`.

## Structure
- Shared package `core_pkg`: the `resultsource` encodings (RESSRC_ALURESULT=00, RESSRC_MEM=01, RESSRC_ALUOUT=10, RESSRC_ZERO=11), the NOP constant, and the IR field bit positions. The control unit uses the same encodings.
- One sub-module: `en_reg` (parameterised-width register with async active-high reset, reset value parameter and load enable). Used for PC, OldPC and IR. Unconditional registers use `en_reg` with enable tied high.

## Test plan
- Reset with `RESET_PC`=32'h100, then release -> `pc`=`old_pc`=32'h100, `instr`=32'h13, `opcode`=7'h13, `instr_count`=0. Asserting reset between clock edges clears the outputs immediately.
- `mem_rdata`=32'h0051_8233 (add x4,x3,x5) with `irwrite`=1 and `pc`=32'h100 -> next cycle `opcode`=7'h33, `rd`=4, `rs1`=3, `rs2`=5, `funct3`=0, `func7_bit5`=0, `old_pc`=32'h100, `instr_count`=1.
- `resultsource`=00, `alu_result`=32'h104, `pcwrite`=1 -> `pc`=32'h104, `pc_misaligned`=0. Then `alu_result`=32'h10A with `pcwrite`=1 -> `pc`=32'h108, `pc_misaligned`=1, still 1 after 5 further normal writes.
- `irwrite`=`pcwrite`=1 at `pc`=32'h200 with `result`=32'h204 -> `old_pc`=32'h200, `pc`=32'h204.
- Result mux: `alu_result`=A, `mdr`=B, `alu_out`=C with distinct values -> `result` equals A, B, C, 0 for selects 00/01/10/11. `adrsource`=1 -> `mem_addr`=`result`. `rd2`=32'hDEAD_BEEF -> `mem_wdata`=32'hDEAD_BEEF one cycle later.
- Preload `instr_count` by 2^32−1 `irwrite` pulses (or a force) to 32'hFFFF_FFFF -> one more `irwrite` gives 0.
